// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-slave SRAM responder: word-organised memory, byte-lane writes,
// configurable OKAY wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int          MEM_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic [31:0] haddr,
  input  logic [31:0] hwdata,
  input  logic [2:0]  hburst,
  input  logic [2:0]  hsize,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  output logic        hready,
  output logic [31:0] hrdata,
  output logic        hresp
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN      = 32'(MEM_WORDS) * 32'd4;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state, state_nxt;
  logic [3:0]      wait_cnt;
  logic [AW+1:0]   off_q;
  logic [2:0]      size_q;
  logic            write_q;
  logic [31:0]     offset;
  logic            legal;
  logic            sample;
  logic [3:0]      lane_en;
  logic [AW-1:0]   word_q;
  logic [31:0]     mem [MEM_WORDS];

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers both bounds.
  assign offset = haddr - BASE_ADDR;
  assign sample = hready && htrans[1];
  assign word_q = off_q[AW+1:2];

  always_comb begin
    legal = 1'b0;
    if (offset < SPAN) begin
      case (hsize)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~haddr[0];
        3'b010:  legal = (haddr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    hready    = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_WAIT: begin
        hready = 1'b0;
        if (wait_cnt == 4'd0) state_nxt = S_DATA;
      end
      S_ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2:  hresp = 1'b1;
      default: ;
    endcase
    if (hready) begin
      if (!htrans[1])            state_nxt = S_IDLE;
      else if (!legal)           state_nxt = S_ERR1;
      else if (WAIT_STATES > 0)  state_nxt = S_WAIT;
      else                       state_nxt = S_DATA;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      off_q    <= '0;
      size_q   <= 3'b000;
      write_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (sample && legal)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
      if (sample) begin
        off_q   <= offset[AW+1:0];
        size_q  <= hsize;
        write_q <= hwrite;
      end
    end
  end

  always_comb begin
    case (size_q)
      3'b000:  lane_en = 4'b0001 << off_q[1:0];
      3'b001:  lane_en = off_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = 4'b1111;
    endcase
  end

  // NOTE: the memory array has no reset; only the pending write is suppressed while hrst is high.
  always_ff @(posedge hclk) begin
    if (!hrst && state == S_DATA && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[word_q][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Read data is only driven in the final OKAY cycle, straight from the array.
  assign hrdata = (state == S_DATA) ? mem[word_q] : 32'h0;

  logic unused_bits;
  assign unused_bits = ^{hburst, offset[31:AW+2]};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: three instances with 0, 2 and 1 wait states,
// 16-word memory at base 0, driven and checked cycle by cycle.
module tb_ahb_sram_slave;

  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;
  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  logic        hclk;
  logic        hrst;
  logic [31:0] haddr  [3];
  logic [31:0] hwdata [3];
  logic [2:0]  hburst [3];
  logic [2:0]  hsize  [3];
  logic [1:0]  htrans [3];
  logic        hwrite [3];
  logic        hready [3];
  logic [31:0] hrdata [3];
  logic        hresp  [3];

  int tests = 0;
  int fails = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_sram_slave #(
      .MEM_WORDS  (16),
      .BASE_ADDR  (32'h0000_0000),
      .WAIT_STATES((g == 0) ? 0 : ((g == 1) ? 2 : 1))
    ) u_dut (
      .hclk  (hclk),
      .hrst  (hrst),
      .haddr (haddr[g]),
      .hwdata(hwdata[g]),
      .hburst(hburst[g]),
      .hsize (hsize[g]),
      .htrans(htrans[g]),
      .hwrite(hwrite[g]),
      .hready(hready[g]),
      .hrdata(hrdata[g]),
      .hresp (hresp[g])
    );
  end

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input int d, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] a);
    htrans[d] = tr;
    hwrite[d] = wr;
    hsize[d]  = sz;
    haddr[d]  = a;
  endtask

  task automatic idle(input int d);
    drive(d, IDLE, 1'b0, SZ_W, 32'h0);
  endtask

  // Single non-pipelined transfer starting from an idle bus; returns the final-cycle response.
  task automatic do_xfer(input int d, input logic wr, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic rsp);
    int n;
    drive(d, NONSEQ, wr, sz, a);
    tick();
    idle(d);
    hwdata[d] = wd;
    n = 0;
    while (!hready[d] && n < 20) begin
      tick();
      n++;
    end
    check("xfer_hready_bound", {31'h0, hready[d]}, 32'h1);
    rd  = hrdata[d];
    rsp = hresp[d];
    tick();
  endtask

  initial begin
    logic [31:0] rd;
    logic        rsp;

    hrst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      idle(d);
      hwdata[d] = 32'h0;
      hburst[d] = 3'b000;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      check("rst_hready", {31'h0, hready[d]}, 32'h1);
      check("rst_hresp",  {31'h0, hresp[d]},  32'h0);
      check("rst_hrdata", hrdata[d],          32'h0);
    end
    hrst = 1'b0;

    // Back-to-back word write then read, no wait states.
    drive(0, NONSEQ, 1'b1, SZ_W, 32'h10);
    tick();
    check("b2b_wr_hready", {31'h0, hready[0]}, 32'h1);
    drive(0, NONSEQ, 1'b0, SZ_W, 32'h10);
    hwdata[0] = 32'hDEAD_BEEF;
    tick();
    check("b2b_rd_hready", {31'h0, hready[0]}, 32'h1);
    check("b2b_rd_hresp",  {31'h0, hresp[0]},  32'h0);
    check("b2b_rd_hrdata", hrdata[0],          32'hDEAD_BEEF);
    idle(0);
    tick();
    check("b2b_idle_hrdata", hrdata[0], 32'h0);

    // Two wait states on a read.
    do_xfer(1, 1'b1, SZ_W, 32'h04, 32'h0BAD_F00D, rd, rsp);
    drive(1, NONSEQ, 1'b0, SZ_W, 32'h04);
    tick();
    check("ws2_c1_hready", {31'h0, hready[1]}, 32'h0);
    check("ws2_c1_hrdata", hrdata[1],          32'h0);
    idle(1);
    tick();
    check("ws2_c2_hready", {31'h0, hready[1]}, 32'h0);
    check("ws2_c2_hrdata", hrdata[1],          32'h0);
    tick();
    check("ws2_c3_hready", {31'h0, hready[1]}, 32'h1);
    check("ws2_c3_hresp",  {31'h0, hresp[1]},  32'h0);
    check("ws2_c3_hrdata", hrdata[1],          32'h0BAD_F00D);
    tick();

    // Byte and halfword lane merging.
    do_xfer(0, 1'b1, SZ_W, 32'h10, 32'h1122_3344, rd, rsp);
    do_xfer(0, 1'b1, SZ_B, 32'h13, 32'hAA77_6655, rd, rsp);
    check("byte_wr_hresp", {31'h0, rsp}, 32'h0);
    do_xfer(0, 1'b1, SZ_H, 32'h10, 32'h9999_5566, rd, rsp);
    do_xfer(0, 1'b0, SZ_W, 32'h10, 32'h0, rd, rsp);
    check("lanes_rd", rd, 32'hAA22_5566);

    // Out-of-range and misaligned writes, second one presented during ERR2.
    do_xfer(0, 1'b1, SZ_W, 32'h00, 32'h0102_0304, rd, rsp);
    drive(0, NONSEQ, 1'b1, SZ_W, 32'h40);
    tick();
    check("oor_err1_hready", {31'h0, hready[0]}, 32'h0);
    check("oor_err1_hresp",  {31'h0, hresp[0]},  32'h1);
    idle(0);
    hwdata[0] = 32'hFFFF_FFFF;
    tick();
    check("oor_err2_hready", {31'h0, hready[0]}, 32'h1);
    check("oor_err2_hresp",  {31'h0, hresp[0]},  32'h1);
    check("oor_err2_hrdata", hrdata[0],          32'h0);
    drive(0, NONSEQ, 1'b1, SZ_H, 32'h01);
    tick();
    check("mis_err1_hready", {31'h0, hready[0]}, 32'h0);
    check("mis_err1_hresp",  {31'h0, hresp[0]},  32'h1);
    idle(0);
    tick();
    check("mis_err2_hready", {31'h0, hready[0]}, 32'h1);
    check("mis_err2_hresp",  {31'h0, hresp[0]},  32'h1);
    drive(0, NONSEQ, 1'b0, SZ_W, 32'h00);
    tick();
    check("err_rd_hresp",  {31'h0, hresp[0]}, 32'h0);
    check("err_rd_hrdata", hrdata[0],         32'h0102_0304);
    idle(0);
    tick();

    // INCR4 burst with a BUSY beat, one wait state.
    hburst[2] = 3'b011;
    drive(2, NONSEQ, 1'b1, SZ_W, 32'h20);
    tick();
    check("bst_b0_wait", {31'h0, hready[2]}, 32'h0);
    drive(2, SEQ, 1'b1, SZ_W, 32'h24);
    hwdata[2] = 32'hA000_0020;
    tick();
    check("bst_b0_data", {31'h0, hready[2]}, 32'h1);
    tick();
    check("bst_b1_wait", {31'h0, hready[2]}, 32'h0);
    drive(2, BUSY, 1'b1, SZ_W, 32'h28);
    hwdata[2] = 32'hA000_0024;
    tick();
    check("bst_b1_data", {31'h0, hready[2]}, 32'h1);
    tick();
    check("bst_busy_hready", {31'h0, hready[2]}, 32'h1);
    check("bst_busy_hresp",  {31'h0, hresp[2]},  32'h0);
    drive(2, SEQ, 1'b1, SZ_W, 32'h28);
    hwdata[2] = 32'hBAD0_BAD0;
    tick();
    check("bst_b2_wait", {31'h0, hready[2]}, 32'h0);
    drive(2, SEQ, 1'b1, SZ_W, 32'h2C);
    hwdata[2] = 32'hA000_0028;
    tick();
    check("bst_b2_data", {31'h0, hready[2]}, 32'h1);
    tick();
    check("bst_b3_wait", {31'h0, hready[2]}, 32'h0);
    idle(2);
    hburst[2] = 3'b000;
    hwdata[2] = 32'hA000_002C;
    tick();
    check("bst_b3_data", {31'h0, hready[2]}, 32'h1);
    tick();
    for (int i = 0; i < 4; i++) begin
      do_xfer(2, 1'b0, SZ_W, 32'h20 + 32'(4 * i), 32'h0, rd, rsp);
      check("bst_readback", rd, 32'hA000_0020 + 32'(4 * i));
    end

    // Reset during the wait states of a write.
    do_xfer(1, 1'b1, SZ_W, 32'h08, 32'h5A5A_5A5A, rd, rsp);
    drive(1, NONSEQ, 1'b1, SZ_W, 32'h08);
    tick();
    idle(1);
    hwdata[1] = 32'hFFFF_FFFF;
    tick();
    check("rstw_in_wait", {31'h0, hready[1]}, 32'h0);
    hrst = 1'b1;
    tick();
    check("rstw_hready", {31'h0, hready[1]}, 32'h1);
    check("rstw_hresp",  {31'h0, hresp[1]},  32'h0);
    check("rstw_hrdata", hrdata[1],          32'h0);
    hrst = 1'b0;
    tick();
    do_xfer(1, 1'b0, SZ_W, 32'h08, 32'h0, rd, rsp);
    check("rstw_word_kept", rd, 32'h5A5A_5A5A);
    do_xfer(0, 1'b0, SZ_W, 32'h10, 32'h0, rd, rsp);
    check("rst_mem_kept", rd, 32'hAA22_5566);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
AHB-Lite responder with an internal word-organised memory; it is the slave-side counterpart to the bus master driving the shared AHB interface. It captures address phases, applies a parameterised number of wait states, writes byte lanes or returns read data, and issues two-cycle ERROR responses on illegal accesses. It is a single-slave system with no hsel: hready out is also the system hready seen by the master.

Parameters:
MEM_WORDS, 256, memory depth in 32-bit words (power of 2, 4..4096)
BASE_ADDR, 32'h0000_0000, byte address of word 0 (4-byte aligned)
WAIT_STATES, 0, hready-low cycles inserted in every OKAY data phase (0..15)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hrst  in  1  synchronous active-high reset
haddr  in  32  byte address (address phase)
hwdata  in  32  write data (data phase)
hburst  in  3  burst type; accepted, not decoded (slave uses haddr each beat)
hsize  in  3  000 byte, 001 half, 010 word; others illegal
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 write, 0 read
hready  out  1  transfer done / address phase sampled
hrdata  out  32  read data
hresp  out  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (hrst=1 at edge): state IDLE, hready=1, hresp=0, hrdata=0, captured-phase registers cleared, wait counter 0; pending write dropped; memory contents NOT cleared. Reset mid-wait or mid-error aborts the transfer.
- Address sampling: at a rising edge with hready=1 and htrans[1]=1, capture haddr, hsize, hwrite. IDLE/BUSY with hready=1: no data phase; next cycle OKAY, hready=1.
- Legality: offset = haddr-BASE_ADDR; legal iff BASE_ADDR<=haddr<BASE_ADDR+4*MEM_WORDS, hsize<=010, haddr aligned to hsize (half: bit0=0; word: bits1:0=00).
- States: IDLE (no data phase), WAIT (hready=0, hresp=0, counter counts WAIT_STATES-1 down to 0), DATA (hready=1, hresp=0, final OKAY cycle), ERR1 (hready=0, hresp=1), ERR2 (hready=1, hresp=1).
- Transitions on sampled legal transfer: ->WAIT if WAIT_STATES>0 else ->DATA; WAIT->DATA when counter=0. Illegal transfer: ->ERR1 (no wait states), ERR1->ERR2 always. DATA/ERR2 sample the next address phase like IDLE; no valid transfer -> IDLE.
- OKAY latency: data phase = WAIT_STATES+1 cycles after address-phase edge.
- Write: committed at the edge ending DATA; lanes: byte -> lane haddr[1:0]; half -> lanes 1:0 or 3:2 by haddr[1]; word -> all. Little-endian, hwdata lane n = bits 8n+7:8n. Unselected lanes unchanged. Errored writes never modify memory.
- Read: hrdata = mem[offset[..:2]] full word, combinational from array during DATA; 0 in all other states. Read after write to same address, back-to-back, returns the new data (write committed before read's DATA cycle).
- Master may change htrans to IDLE during ERR1; ignored (hready=0). Address phase presented during ERR2 is sampled normally.
- hburst ignored; wrap/incrementing addresses are master's responsibility; each beat checked independently.

Test Plan:
- WAIT_STATES=0: word write 0xDEADBEEF @0x10 then read @0x10 back-to-back -> hready stays 1, read DATA cycle hrdata=0xDEADBEEF, hresp=0.
- WAIT_STATES=2: single read NONSEQ @0x04 -> hready 0,0,1 on three cycles after address edge; data valid only on third.
- Byte write 0xAA to 0x13 over word 0x11223344 @0x10, half write 0x5566 to 0x10 -> read @0x10 returns 0xAA225566.
- Write @BASE+4*MEM_WORDS, and half write @0x01 -> each: ERR1 (hready=0,hresp=1), ERR2 (hready=1,hresp=1); memory unchanged on readback.
- INCR4 burst NONSEQ/SEQ/BUSY/SEQ/SEQ writes @0x20..0x2C, WAIT_STATES=1 -> BUSY gives zero-wait OKAY, four words written, readback matches.
- hrst asserted during WAIT of a write -> next cycle hready=1, hresp=0, hrdata=0, target word unchanged.
